pipe_hazard_ctrl: RTL and testbench

//  Issue-side hazard and sequencing controller for the 5-stage pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Issue-side hazard controller: register scoreboard for RAW/WAW stalls,
// multi-cycle multiplier sequencing and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int NREG    = 32,
  parameter int RW      = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [RW-1:0]     issue_rs1,
  input  logic [RW-1:0]     issue_rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [RW-1:0]     issue_rd,
  input  logic              issue_we,
  input  logic              issue_mul,
  input  logic              wb_we,
  input  logic [RW-1:0]     wb_rd,
  input  logic              flush,
  output logic              stall,
  output logic              issue_fire,
  output logic              adv_d2,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state,
  output logic [NREG-1:0]   dbg_pend
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int MCW = $clog2(MUL_LAT + 1);
  localparam logic [MCW-1:0] MUL_INIT = MCW'(MUL_LAT - 1);

  state_e            state_q, state_d;
  logic [MCW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [RW-1:0]     mul_rd_q, mul_rd_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              haz;

  // Issue handshake: issue_valid is the offer, ~stall the acceptance; an
  // instruction is taken (issue_fire) only when both hold and no flush is active.
  // haz looks at registered pend only: the register file is not write-through,
  // so a same-cycle write-back still costs one stall cycle.
  always_comb begin
    haz = 1'b0;
    if (rs1_used && issue_rs1 != '0 && pend_q[issue_rs1]) haz = 1'b1;
    if (rs2_used && issue_rs2 != '0 && pend_q[issue_rs2]) haz = 1'b1;
    if (issue_we && issue_rd  != '0 && pend_q[issue_rd])  haz = 1'b1;
  end

  always_comb begin
    mul_busy   = (state_q != S_IDLE);
    mul_done   = (state_q == S_DONE) && !flush;
    stall      = issue_valid && (haz || mul_busy) && !flush;
    issue_fire = issue_valid && !stall && !flush;
    adv_d2     = issue_fire || mul_done;
    stall_cnt  = stall_cnt_q;
    dbg_state  = state_q;
    dbg_pend   = pend_q;
  end

  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    mul_rd_d    = mul_rd_q;
    pend_d      = pend_q;
    stall_cnt_d = stall_cnt_q;

    if (wb_we && wb_rd != '0) pend_d[wb_rd] = 1'b0;
    if (issue_fire && issue_we && issue_rd != '0) pend_d[issue_rd] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (issue_fire && issue_mul) begin
          state_d   = S_MUL;
          mul_cnt_d = MUL_INIT;
          mul_rd_d  = issue_rd;
        end
      end
      S_MUL: begin
        mul_cnt_d = mul_cnt_q - MCW'(1);
        if (mul_cnt_q == MCW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A killed multiply never writes back, so its scoreboard entry is dropped here.
    if (flush) begin
      state_d   = S_IDLE;
      mul_cnt_d = '0;
      if (state_q != S_IDLE && mul_rd_q != '0) pend_d[mul_rd_q] = 1'b0;
    end

    if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mul_cnt_q   <= '0;
      mul_rd_q    <= '0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      mul_rd_q    <= mul_rd_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle vector table plus hand-written
// flush, asynchronous reset and stall-counter saturation sequences.
module tb_pipe_hazard_ctrl;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        rs1_used, rs2_used, issue_we, issue_mul, wb_we, flush;

  logic        stall, issue_fire, adv_d2, mul_busy, mul_done;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_pend;

  logic        s_stall, s_fire, s_adv, s_busy, s_done;
  logic [3:0]  s_cnt;
  logic [1:0]  s_state;
  logic [31:0] s_pend;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we, mul, wbwe;
    logic [4:0] wbrd;
    logic       fl;
    logic       e_stall, e_fire, e_adv, e_busy, e_done;
    logic [31:0] e_pend;
    int         e_cnt;
  } vec_t;

  vec_t vecs[28];

  pipe_hazard_ctrl u_dut (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_rd(issue_rd), .issue_we(issue_we), .issue_mul(issue_mul),
    .wb_we(wb_we), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .issue_fire(issue_fire), .adv_d2(adv_d2), .mul_busy(mul_busy),
    .mul_done(mul_done), .stall_cnt(stall_cnt), .dbg_state(dbg_state), .dbg_pend(dbg_pend)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_rd(issue_rd), .issue_we(issue_we), .issue_mul(issue_mul),
    .wb_we(wb_we), .wb_rd(wb_rd), .flush(flush),
    .stall(s_stall), .issue_fire(s_fire), .adv_d2(s_adv), .mul_busy(s_busy),
    .mul_done(s_done), .stall_cnt(s_cnt), .dbg_state(s_state), .dbg_pend(s_pend)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
    input logic [4:0] rd, input logic we, input logic mul, input logic wbwe, input logic [4:0] wbrd,
    input logic fl, input logic es, input logic ef, input logic ea, input logic eb, input logic ed,
    input logic [31:0] ep, input int ec);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd; r.we = we;
    r.mul = mul; r.wbwe = wbwe; r.wbrd = wbrd; r.fl = fl;
    r.e_stall = es; r.e_fire = ef; r.e_adv = ea; r.e_busy = eb; r.e_done = ed;
    r.e_pend = ep; r.e_cnt = ec;
    return r;
  endfunction

  // driver tasks
  task automatic drive(input vec_t x);
    issue_valid = x.v; issue_rs1 = x.rs1; issue_rs2 = x.rs2; rs1_used = x.u1; rs2_used = x.u2;
    issue_rd = x.rd; issue_we = x.we; issue_mul = x.mul; wb_we = x.wbwe; wb_rd = x.wbrd;
    flush = x.fl;
  endtask

  task automatic drive_idle();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // mk(v,rs1,rs2,u1,u2,rd,we,mul,wbwe,wbrd,fl, stall,fire,adv,busy,done, pend,cnt)
    vecs[0]  = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 32'h0,0);
    vecs[1]  = mk(1,0,0,0,0,3,1,0,0,0,0, 0,1,1,0,0, 32'h0,0);
    vecs[2]  = mk(1,3,0,1,0,4,1,0,0,0,0, 1,0,0,0,0, 32'h8,0);
    vecs[3]  = mk(1,3,0,1,0,4,1,0,0,0,0, 1,0,0,0,0, 32'h8,1);
    vecs[4]  = mk(1,3,0,1,0,4,1,0,1,3,0, 1,0,0,0,0, 32'h8,2);
    vecs[5]  = mk(1,3,0,1,0,4,1,0,0,0,0, 0,1,1,0,0, 32'h0,3);
    vecs[6]  = mk(1,0,0,0,0,7,1,0,0,0,0, 0,1,1,0,0, 32'h10,3);
    vecs[7]  = mk(1,0,0,0,0,7,1,0,0,0,0, 1,0,0,0,0, 32'h90,3);
    vecs[8]  = mk(1,0,0,0,0,7,1,0,1,4,0, 1,0,0,0,0, 32'h90,4);
    vecs[9]  = mk(1,0,0,0,0,7,1,0,1,7,0, 1,0,0,0,0, 32'h80,5);
    vecs[10] = mk(1,0,0,0,0,7,1,0,0,0,0, 0,1,1,0,0, 32'h0,6);
    vecs[11] = mk(1,0,0,0,0,0,1,0,1,7,0, 0,1,1,0,0, 32'h80,6);
    vecs[12] = mk(1,0,0,1,1,0,1,0,0,0,0, 0,1,1,0,0, 32'h0,6);
    vecs[13] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 32'h0,6);
    vecs[14] = mk(1,0,0,0,0,9,1,1,0,0,0, 0,1,1,0,0, 32'h0,6);
    vecs[15] = mk(1,1,0,1,0,5,1,0,0,0,0, 1,0,0,1,0, 32'h200,6);
    vecs[16] = mk(1,1,0,1,0,5,1,0,0,0,0, 1,0,0,1,0, 32'h200,7);
    vecs[17] = mk(1,1,0,1,0,5,1,0,0,0,0, 1,0,0,1,0, 32'h200,8);
    vecs[18] = mk(1,1,0,1,0,5,1,0,0,0,0, 1,0,1,1,1, 32'h200,9);
    vecs[19] = mk(1,1,0,1,0,5,1,0,0,0,0, 0,1,1,0,0, 32'h200,10);
    vecs[20] = mk(0,0,0,0,0,0,0,0,1,9,0, 0,0,0,0,0, 32'h220,10);
    vecs[21] = mk(0,0,0,0,0,0,0,0,1,5,0, 0,0,0,0,0, 32'h20,10);
    vecs[22] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 32'h0,10);
    vecs[23] = mk(1,0,0,0,0,6,1,0,0,0,0, 0,1,1,0,0, 32'h0,10);
    vecs[24] = mk(1,0,6,0,1,8,0,0,0,0,0, 1,0,0,0,0, 32'h40,10);
    vecs[25] = mk(1,6,6,0,0,6,0,0,0,0,0, 0,1,1,0,0, 32'h40,11);
    vecs[26] = mk(0,0,0,0,0,0,0,0,1,6,0, 0,0,0,0,0, 32'h40,11);
    vecs[27] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 32'h0,11);

    reset_n = 1'b0;
    drive_idle();
    #2;
    chk("reset state", {30'd0, dbg_state}, 32'd0);
    chk("reset pend", dbg_pend, 32'h0);
    chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset outs", {27'd0, stall, issue_fire, adv_d2, mul_busy, mul_done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();

    // table: RAW, WAW, r0, multiply, rs2 hazard, unused sources
    for (int k = 0; k < 28; k++) begin
      drive(vecs[k]);
      @(negedge clock);
      chk($sformatf("vec%0d stall", k), {31'd0, stall}, {31'd0, vecs[k].e_stall});
      chk($sformatf("vec%0d fire", k), {31'd0, issue_fire}, {31'd0, vecs[k].e_fire});
      chk($sformatf("vec%0d adv_d2", k), {31'd0, adv_d2}, {31'd0, vecs[k].e_adv});
      chk($sformatf("vec%0d busy", k), {31'd0, mul_busy}, {31'd0, vecs[k].e_busy});
      chk($sformatf("vec%0d done", k), {31'd0, mul_done}, {31'd0, vecs[k].e_done});
      chk($sformatf("vec%0d pend", k), dbg_pend, vecs[k].e_pend);
      chk($sformatf("vec%0d stall_cnt", k), {16'd0, stall_cnt}, vecs[k].e_cnt);
      next_cycle();
    end

    // flush at T+2 of a multiply to r9
    drive(mk(1,0,0,0,0,9,1,1,0,0,0, 0,0,0,0,0, 0,0));
    @(negedge clock);
    chk("flush mul fire", {31'd0, issue_fire}, 32'd1);
    next_cycle();
    drive_idle();
    @(negedge clock);
    chk("flush T+1 state", {30'd0, dbg_state}, 32'd1);
    chk("flush T+1 pend", dbg_pend, 32'h200);
    next_cycle();
    drive(mk(1,0,0,0,0,10,1,0,0,0,1, 0,0,0,0,0, 0,0));
    @(negedge clock);
    chk("flush T+2 outs", {28'd0, stall, issue_fire, adv_d2, mul_done}, 32'd0);
    chk("flush T+2 busy", {31'd0, mul_busy}, 32'd1);
    next_cycle();
    drive_idle();
    @(negedge clock);
    chk("flush T+3 state", {30'd0, dbg_state}, 32'd0);
    chk("flush T+3 busy", {31'd0, mul_busy}, 32'd0);
    chk("flush T+3 pend", dbg_pend, 32'h0);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clock);
      chk($sformatf("flush no done %0d", i), {31'd0, mul_done}, 32'd0);
    end
    next_cycle();

    // asynchronous reset in the middle of a multiply, pend = r3 | r9
    drive(mk(1,0,0,0,0,3,1,0,0,0,0, 0,0,0,0,0, 0,0));
    @(negedge clock);
    chk("areset r3 fire", {31'd0, issue_fire}, 32'd1);
    next_cycle();
    drive(mk(1,0,0,0,0,9,1,1,0,0,0, 0,0,0,0,0, 0,0));
    @(negedge clock);
    chk("areset mul fire", {31'd0, issue_fire}, 32'd1);
    next_cycle();
    drive_idle();
    @(negedge clock);
    chk("areset pre pend", dbg_pend, 32'h208);
    chk("areset pre state", {30'd0, dbg_state}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset pend", dbg_pend, 32'h0);
    chk("areset state", {30'd0, dbg_state}, 32'd0);
    chk("areset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("areset outs", {27'd0, stall, issue_fire, adv_d2, mul_busy, mul_done}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk($sformatf("areset hold done %0d", i), {31'd0, mul_done}, 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clock);
      chk($sformatf("areset post done %0d", i), {31'd0, mul_done}, 32'd0);
    end
    next_cycle();

    // stall counter saturation: 20 stall cycles on a RAW hazard
    drive(mk(1,0,0,0,0,3,1,0,0,0,0, 0,0,0,0,0, 0,0));
    next_cycle();
    drive(mk(1,3,0,1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk($sformatf("sat stall %0d", i), {31'd0, stall}, 32'd1);
      next_cycle();
    end
    chk("sat cnt16", {16'd0, stall_cnt}, 32'd20);
    chk("sat cnt4", {28'd0, s_cnt}, 32'd15);
    drive(mk(0,0,0,0,0,0,0,0,1,3,0, 0,0,0,0,0, 0,0));
    next_cycle();
    drive_idle();
    @(negedge clock);
    chk("sat final pend", dbg_pend, 32'h0);
    chk("sat cnt4 held", {28'd0, s_cnt}, 32'd15);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
